ahb_lite_master: RTL and testbench

- Single-master AHB-Lite initiator that sits directly upstream of the AHB GPIO slave and drives its select, address/control and write-data inputs.
- Accepts simple read/write commands over a valid/ready port and buffers them in a small FIFO.
- Issues the commands as pipelined NONSEQ transfers, with the address phase of N overlapping the data phase of N-1, and returns read data on a response port.

---
 rtl/ahb_master_pkg.sv | 52 +++++
 rtl/ahb_cmd_fifo.sv | 65 ++++++
 rtl/ahb_lite_master.sv | 177 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_pkg.sv
// ----------------------------------------------------------------------------
// ahb_master_pkg
//   Shared types for the AHB-Lite command master: transfer-type and
//   transfer-size encodings, the queued command record, and small helpers
//   used when a command is accepted.
//
//   cmd_t carries fixed-width address/data fields (CMD_AW / CMD_DW). The
//   master's AW and DW parameters must not exceed these widths.
// ----------------------------------------------------------------------------
package ahb_master_pkg;

    localparam int CMD_AW = 32;
    localparam int CMD_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BYTE = 3'b000,
        HALF = 3'b001,
        WORD = 3'b010
    } hsize_e;

    typedef struct packed {
        logic [CMD_AW-1:0] addr;
        logic              write;
        hsize_e            size;
        logic [CMD_DW-1:0] wdata;
    } cmd_t;

    // Anything wider than a word is treated as a word transfer.
    function automatic hsize_e clamp_size(input logic [2:0] size);
        case (size)
            3'b000:  return BYTE;
            3'b001:  return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lsb, input hsize_e size);
        case (size)
            HALF:    return addr_lsb[0];
            WORD:    return |addr_lsb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_cmd_fifo.sv
// ----------------------------------------------------------------------------
// ahb_cmd_fifo
//   Synchronous first-word-fall-through FIFO of cmd_t records.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     push, push_data   write an entry (ignored while full)
//     pop               drop the head entry (ignored while empty)
//     head              current head entry, valid while !empty
//     full, empty       occupancy flags
//
//   DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module ahb_cmd_fifo
    import ahb_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    cmd_t         mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         push_en;
    logic         pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // NOTE: the storage array has no reset; an entry is only observed after
    // it has been written, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // The extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/ahb_lite_master.sv
// ----------------------------------------------------------------------------
// ahb_lite_master
//   Single-master AHB-Lite initiator. Commands arrive on a valid/ready port,
//   are queued in ahb_cmd_fifo and issued as pipelined NONSEQ transfers: the
//   address phase of transfer N overlaps the data phase of transfer N-1.
//   Read data is returned on rsp_valid/rsp_rdata in command order; writes
//   produce no response.
//
//   Ports:
//     clk, reset                    clock, asynchronous active-high reset
//     cmd_valid/ready/addr/write/size/wdata   command input
//     rsp_valid, rsp_rdata          one-cycle read response
//     busy                          queue non-empty or data phase pending
//     ahb_sel/addr/trans/write/size address phase to the slave
//     ahb_wdata                     data-phase write data
//     ahb_ready                     bus ready back to the slave (= ahb_readyout)
//     ahb_readyout, ahb_rdata       slave response
//     cmd_err                       (AHB_MASTER_ALIGN_CHECK_EN only) pulses the
//                                   cycle after a misaligned command is dropped
//
//   Build option: define AHB_MASTER_ALIGN_CHECK_EN to drop misaligned
//   commands and report them on cmd_err.
// ----------------------------------------------------------------------------
module ahb_lite_master
    import ahb_master_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic          cmd_write,
    input  logic [2:0]    cmd_size,
    input  logic [DW-1:0] cmd_wdata,

    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    output logic          cmd_err,
`endif

    output logic          ahb_sel,
    output logic [AW-1:0] ahb_addr,
    output logic [1:0]    ahb_trans,
    output logic          ahb_write,
    output logic [2:0]    ahb_size,
    output logic [DW-1:0] ahb_wdata,
    output logic          ahb_ready,
    input  logic          ahb_readyout,
    input  logic [DW-1:0] ahb_rdata
);

    cmd_t          push_cmd;
    cmd_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          push;
    logic          pop;

    // Last issued address/control, held on the bus while the queue is empty.
    logic [AW-1:0] addr_q;
    logic          write_q;
    hsize_e        size_q;

    // Data-phase stage.
    logic          dp_valid;
    logic          dp_write;
    logic [DW-1:0] dp_wdata;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push_cmd       = '0;
        push_cmd.addr  = CMD_AW'(cmd_addr);
        push_cmd.write = cmd_write;
        push_cmd.size  = clamp_size(cmd_size);
        push_cmd.wdata = CMD_DW'(cmd_wdata);
    end

    // Ready comes from the pre-pop occupancy, so a full queue never accepts
    // even when the head is leaving on the same edge.
    assign cmd_ready = !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign ahb_ready = ahb_readyout;
    assign pop       = !fifo_empty && ahb_ready;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
    logic misaligned;

    assign misaligned = is_misaligned(push_cmd.addr[1:0], push_cmd.size);
    assign push       = accept && !misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cmd_err <= 1'b0;
        else       cmd_err <= accept && misaligned;
    end
`else
    assign push = accept;
`endif

    ahb_cmd_fifo #(
        .DEPTH     (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= BYTE;
        end else if (!fifo_empty) begin
            addr_q  <= head.addr[AW-1:0];
            write_q <= head.write;
            size_q  <= head.size;
        end
    end

    // Address phase straight from the queue head.
    always_comb begin
        ahb_sel   = 1'b0;
        ahb_trans = IDLE;
        ahb_addr  = addr_q;
        ahb_write = write_q;
        ahb_size  = size_q;
        if (!fifo_empty) begin
            ahb_sel   = 1'b1;
            ahb_trans = NONSEQ;
            ahb_addr  = head.addr[AW-1:0];
            ahb_write = head.write;
            ahb_size  = head.size;
        end
    end

    // The stage only moves on ready edges; a pop on the completing edge
    // refills it, so consecutive transfers need no idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (ahb_ready) begin
                if (dp_valid && !dp_write) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ahb_rdata;
                end
                dp_valid <= pop;
                if (pop) begin
                    dp_write <= head.write;
                    if (head.write) dp_wdata <= head.wdata[DW-1:0];
                end
            end
        end
    end

    assign ahb_wdata = dp_wdata;
    assign busy      = !fifo_empty || dp_valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_master
//   Directed bench for ahb_lite_master. Expected read responses are queued
//   when a read is issued; a monitor pops and compares on every rsp_valid.
//   The slave model returns {addr[23:0], 8'hA5} for the data phase of the
//   transfer it last accepted.
// ----------------------------------------------------------------------------
module tb_ahb_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    logic          cmd_err;
`endif
    logic          ahb_sel;
    logic [AW-1:0] ahb_addr;
    logic [1:0]    ahb_trans;
    logic          ahb_write;
    logic [2:0]    ahb_size;
    logic [DW-1:0] ahb_wdata;
    logic          ahb_ready;
    logic          ahb_readyout;
    logic [DW-1:0] ahb_rdata;

    int            total = 0;
    int            bad = 0;
    int            rsp_count = 0;
    int            nonseq_seen = 0;
    logic [31:0]   last_nonseq_addr = '0;
    logic [31:0]   exp_q [$];
    logic [31:0]   nxt_addr = '0;
    logic [31:0]   dp_addr_tb = '0;
    int            base;
    int            base_ns;

    logic [31:0]   t3_addr  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic          t3_write [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0]   t3_data  [4] = '{32'h1, 32'h0, 32'h3, 32'h0};

    always #5 clk = ~clk;

    ahb_lite_master #(
        .CMD_DEPTH    (4),
        .AW           (AW),
        .DW           (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_write    (cmd_write),
        .cmd_size     (cmd_size),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
`ifdef AHB_MASTER_ALIGN_CHECK_EN
        .cmd_err      (cmd_err),
`endif
        .ahb_sel      (ahb_sel),
        .ahb_addr     (ahb_addr),
        .ahb_trans    (ahb_trans),
        .ahb_write    (ahb_write),
        .ahb_size     (ahb_size),
        .ahb_wdata    (ahb_wdata),
        .ahb_ready    (ahb_ready),
        .ahb_readyout (ahb_readyout),
        .ahb_rdata    (ahb_rdata)
    );

    // Slave model: inputs change only on falling edges, so sampling just
    // after the falling edge sees what the rising edge will see.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            nxt_addr = '0;
        end else if (ahb_readyout && ahb_trans == 2'b10) begin
            nxt_addr = ahb_addr;
            last_nonseq_addr = ahb_addr;
            nonseq_seen++;
        end
    end

    always @(posedge clk) dp_addr_tb <= nxt_addr;

    assign ahb_rdata = {dp_addr_tb[23:0], 8'hA5};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got 0x%08h, wanted no response", rsp_rdata);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_size  = s;
        cmd_wdata = d;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_trans"},     32'(ahb_trans), 32'h0);
        check({tag, "_sel"},       32'(ahb_sel),   32'h0);
        check({tag, "_addr"},      ahb_addr,       32'h0);
        check({tag, "_write"},     32'(ahb_write), 32'h0);
        check({tag, "_size"},      32'(ahb_size),  32'h0);
        check({tag, "_wdata"},     ahb_wdata,      32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_write    = 1'b0;
        cmd_size     = '0;
        cmd_wdata    = '0;
        ahb_readyout = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        step();

        // Single write.
        base = rsp_count;
        drive_cmd(32'h4, 1'b1, 3'd2, 32'hDEAD_BEEF);
        step();
        cmd_valid = 1'b0;
        check("t1_trans", 32'(ahb_trans), 32'h2);
        check("t1_sel",   32'(ahb_sel),   32'h1);
        check("t1_addr",  ahb_addr,       32'h4);
        check("t1_write", 32'(ahb_write), 32'h1);
        check("t1_size",  32'(ahb_size),  32'h2);
        step();
        check("t1_trans_idle", 32'(ahb_trans), 32'h0);
        check("t1_wdata",      ahb_wdata,      32'hDEAD_BEEF);
        check("t1_busy_dp",    32'(busy),      32'h1);
        step();
        check("t1_busy_done",  32'(busy),      32'h0);
        check("t1_no_rsp",     32'(rsp_count - base), 32'h0);

        // Single read; oversized size field must be clamped to a word.
        exp_q.push_back(32'h0000_00A5);
        drive_cmd(32'h0, 1'b0, 3'd5, 32'h0);
        step();
        cmd_valid = 1'b0;
        check("t2_trans", 32'(ahb_trans), 32'h2);
        check("t2_size",  32'(ahb_size),  32'h2);
        step();
        check("t2_rsp_early", 32'(rsp_valid), 32'h0);
        step();
        check("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        step();

        // Four back-to-back commands.
        base = rsp_count;
        exp_q.push_back(32'h0000_04A5);
        exp_q.push_back(32'h0000_0CA5);
        for (int i = 0; i < 4; i++) begin
            drive_cmd(t3_addr[i], t3_write[i], 3'd2, t3_data[i]);
            step();
            check($sformatf("t3_trans%0d", i), 32'(ahb_trans), 32'h2);
            check($sformatf("t3_addr%0d", i),  ahb_addr,       t3_addr[i]);
            if (i > 0 && t3_write[i-1]) check($sformatf("t3_wdata%0d", i-1), ahb_wdata, t3_data[i-1]);
        end
        cmd_valid = 1'b0;
        step();
        check("t3_idle", 32'(ahb_trans), 32'h0);
        repeat (3) step();
        check("t3_rsp_count", 32'(rsp_count - base), 32'h2);

        // Two wait states during the data phase of a write, read queued behind.
        base = rsp_count;
        exp_q.push_back(32'h0000_14A5);
        drive_cmd(32'h10, 1'b1, 3'd2, 32'h55);
        step();
        drive_cmd(32'h14, 1'b0, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        ahb_readyout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_addr%0d", i),  ahb_addr,       32'h14);
            check($sformatf("t4_trans%0d", i), 32'(ahb_trans), 32'h2);
            check($sformatf("t4_wdata%0d", i), ahb_wdata,      32'h55);
            if (i == 2) ahb_readyout = 1'b1;
            step();
        end
        check("t4_issued", 32'(ahb_trans), 32'h0);
        check("t4_rsp_wait", 32'(rsp_valid), 32'h0);
        repeat (3) step();
        check("t4_rsp_count", 32'(rsp_count - base), 32'h1);

        // Fill the queue while the slave stalls; fifth command waits for a pop.
        base_ns = nonseq_seen;
        ahb_readyout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_ready%0d", i), 32'(cmd_ready), 32'h1);
            drive_cmd(32'h20 + 32'(4 * i), 1'b1, 3'd2, 32'(i));
            step();
        end
        check("t5_full", 32'(cmd_ready), 32'h0);
        drive_cmd(32'h30, 1'b1, 3'd2, 32'h4);
        step();
        check("t5_still_full", 32'(cmd_ready), 32'h0);
        check("t5_head0",      ahb_addr,       32'h20);
        ahb_readyout = 1'b1;
        step();
        check("t5_ready_after_pop", 32'(cmd_ready), 32'h1);
        check("t5_head1",           ahb_addr,       32'h24);
        step();
        cmd_valid = 1'b0;
        check("t5_head2", ahb_addr, 32'h28);
        repeat (6) step();
        check("t5_xfers",     32'(nonseq_seen - base_ns), 32'h5);
        check("t5_last_addr", last_nonseq_addr,           32'h30);

        // Reset during the data phase of a read.
        base = rsp_count;
        drive_cmd(32'h40, 1'b0, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        step();
        check("t6_busy_dp", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check_reset_values("t6");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        check("t6_no_rsp", 32'(rsp_count - base), 32'h0);

`ifdef AHB_MASTER_ALIGN_CHECK_EN
        // Misaligned word command is consumed, reported and never issued.
        base_ns = nonseq_seen;
        drive_cmd(32'h2, 1'b0, 3'd2, 32'h0);
        step();
        cmd_valid = 1'b0;
        check("ae_err",   32'(cmd_err),   32'h1);
        check("ae_trans", 32'(ahb_trans), 32'h0);
        check("ae_busy",  32'(busy),      32'h0);
        step();
        check("ae_err_pulse", 32'(cmd_err), 32'h0);
        step();
        check("ae_no_nonseq", 32'(nonseq_seen - base_ns), 32'h0);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
